dm_cache_ctrl: RTL and testbench

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/dm_cache_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// A single request is captured in IDLE, looked up for one cycle, and any
// memory traffic (read refill or write-through) runs through MEM_REQ/MEM_WAIT.
// Every output is a register. The tag and data arrays are deliberately left unreset.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FLUSH
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tagMem  [LINES];
    logic [DATA_W-1:0] r_dataMem [LINES];

    logic              r_capWe;
    logic [ADDR_W-1:0] r_capAddr;
    logic [DATA_W-1:0] r_capWdata;
    logic              r_capHit;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_accept;
    logic               w_writeHit;
    logic               w_fill;

    assign w_index    = r_capAddr[INDEX_W-1:0];
    assign w_tag      = r_capAddr[ADDR_W-1:INDEX_W];
    assign w_hit      = r_valid[w_index] && (r_tagMem[w_index] == w_tag);
    assign w_accept   = (r_state == IDLE) && !flush && req_valid && req_ready;
    assign w_writeHit = (r_state == LOOKUP) && r_capWe && w_hit;
    assign w_fill     = (r_state == MEM_WAIT) && mem_rsp_valid && !r_capWe;

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush takes priority over a pending request in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_nextState = FLUSH;
                end else if (req_valid && req_ready) begin
                    w_nextState = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!r_capWe && w_hit) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    w_nextState = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    w_nextState = IDLE;
                end
            end
            FLUSH: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture the accepted request; lookup and memory phases work from this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capWe    <= 1'b0;
            r_capAddr  <= '0;
            r_capWdata <= '0;
            r_capHit   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_capWe    <= req_we;
                r_capAddr  <= req_addr;
                r_capWdata <= req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_capHit <= w_hit;
            end
        end
    end

    // Valid bits: cleared by reset or flush, set when a read refill lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (r_state == FLUSH) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    // Tag and data arrays: write hits update data, read refills replace the whole line.
    always_ff @(posedge clk) begin
        if (w_writeHit) begin
            r_dataMem[w_index] <= r_capWdata;
        end
        if (w_fill) begin
            r_dataMem[w_index] <= mem_rdata;
            r_tagMem[w_index]  <= w_tag;
        end
    end

    // Registered request/response/memory outputs and saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_hit       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            req_ready <= (w_nextState == IDLE) && !flush;
            rsp_valid <= 1'b0;
            case (r_state)
                LOOKUP: begin
                    if (w_hit) begin
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                    end else begin
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                    end
                    if (!r_capWe && w_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_rdata <= r_dataMem[w_index];
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_we        <= r_capWe;
                        mem_addr      <= r_capAddr;
                        mem_wdata     <= r_capWe ? r_capWdata : '0;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= r_capWe ? r_capHit : 1'b0;
                        rsp_rdata <= r_capWe ? '0 : mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: cold misses, hits, conflict eviction,
// write-through hit/miss, flush priority and reset during an outstanding miss.
module tb_dm_cache_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       flush;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_hit;
    logic       mem_req_valid;
    logic       mem_req_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rsp_valid;
    logic [7:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    dm_cache_ctrl #(
        .ADDR_W(8),
        .DATA_W(8),
        .INDEX_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .flush(flush),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_hit(rsp_hit),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCounters(input string tag, input logic [15:0] expHits, input logic [15:0] expMisses);
        checkOutput({tag, " hit_count"}, 32'(hit_count), 32'(expHits));
        checkOutput({tag, " miss_count"}, 32'(miss_count), 32'(expMisses));
    endtask

    // Present a request and return one cycle after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int waitCycles;
        waitCycles = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput("accept req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Run one full request, playing the memory side, and check every phase.
    task automatic doRequest(input string tag, input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic expHit, input logic [7:0] memData, input logic [7:0] expRdata);
        applyStimulus(we, addr, wdata);
        tick();
        if (expHit && !we) begin
            checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, " rsp_hit"}, 32'(rsp_hit), 32'd1);
            checkOutput({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(expRdata));
            checkOutput({tag, " no mem_req_valid"}, 32'(mem_req_valid), 32'd0);
            checkOutput({tag, " req_ready with rsp"}, 32'(req_ready), 32'd1);
        end else begin
            checkOutput({tag, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
            checkOutput({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd1);
            checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(we));
            checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
            if (we) begin
                checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wdata));
            end
            mem_rsp_valid = 1'b1;
            mem_rdata     = 8'hEE;
            tick();
            mem_rsp_valid = 1'b0;
            checkOutput({tag, " mem_req_valid held"}, 32'(mem_req_valid), 32'd1);
            checkOutput({tag, " mem_addr held"}, 32'(mem_addr), 32'(addr));
            checkOutput({tag, " stray rsp ignored"}, 32'(rsp_valid), 32'd0);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            checkOutput({tag, " mem_req_valid drop"}, 32'(mem_req_valid), 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rdata     = memData;
            tick();
            mem_rsp_valid = 1'b0;
            checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, " rsp_hit"}, 32'(rsp_hit), 32'(expHit));
            checkOutput({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(expRdata));
        end
        tick();
        checkOutput({tag, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    // Directed sequence of cache scenarios.
    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 8'h00;
        req_wdata     = 8'h00;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkCounters("reset", 16'd0, 16'd0);
        rst = 1'b0;
        tick();
        checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

        doRequest("cold read 2A", 1'b0, 8'h2A, 8'h00, 1'b0, 8'h5C, 8'h5C);
        checkCounters("cold read 2A", 16'd0, 16'd1);
        doRequest("repeat read 2A", 1'b0, 8'h2A, 8'h00, 1'b1, 8'h00, 8'h5C);
        checkCounters("repeat read 2A", 16'd1, 16'd1);
        doRequest("conflict read 32", 1'b0, 8'h32, 8'h00, 1'b0, 8'h77, 8'h77);
        doRequest("evicted read 2A", 1'b0, 8'h2A, 8'h00, 1'b0, 8'h5C, 8'h5C);
        checkCounters("eviction", 16'd1, 16'd3);

        doRequest("write hit 2A", 1'b1, 8'h2A, 8'h99, 1'b1, 8'h00, 8'h00);
        doRequest("read after write 2A", 1'b0, 8'h2A, 8'h00, 1'b1, 8'h00, 8'h99);
        checkCounters("write hit", 16'd3, 16'd3);
        doRequest("write miss 40", 1'b1, 8'h40, 8'h11, 1'b0, 8'h00, 8'h00);
        doRequest("read 40 no allocate", 1'b0, 8'h40, 8'h00, 1'b0, 8'h33, 8'h33);
        doRequest("write miss 22", 1'b1, 8'h22, 8'hAB, 1'b0, 8'h00, 8'h00);
        doRequest("line kept 2A", 1'b0, 8'h2A, 8'h00, 1'b1, 8'h00, 8'h99);
        checkCounters("write miss", 16'd4, 16'd6);

        flush     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h2A;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        checkOutput("flush req_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("after flush req_ready", 32'(req_ready), 32'd1);
        checkOutput("after flush rsp_valid", 32'(rsp_valid), 32'd0);
        checkCounters("flush beats request", 16'd4, 16'd6);
        doRequest("read 2A after flush", 1'b0, 8'h2A, 8'h00, 1'b0, 8'h99, 8'h99);
        checkCounters("after flush", 16'd4, 16'd7);

        applyStimulus(1'b0, 8'h13, 8'h00);
        tick();
        checkOutput("inflight mem_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
        checkOutput("midreset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midreset rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkCounters("midreset", 16'd0, 16'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 8'h42;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("midreset rsp ignored", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("stale rsp ignored", 32'(rsp_valid), 32'd0);
        checkOutput("stale rsp req_ready", 32'(req_ready), 32'd1);
        doRequest("read 2A after reset", 1'b0, 8'h2A, 8'h00, 1'b0, 8'h5C, 8'h5C);
        checkCounters("after reset", 16'd0, 16'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
